// File: rtl/activation_stage.sv
// rtl/activation_stage.sv - streaming element-wise activation (identity/ReLU/leaky ReLU/hard sigmoid)
// Two-stage stalled pipeline with frame FSM, last-element tagging and per-frame done pulse.
module activation_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int VECTOR_LEN = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            act_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(VECTOR_LEN - 1);
  localparam logic signed [EW-1:0] HALF    = EW'(1 << (FRAC_BITS - 1));
  localparam logic signed [EW-1:0] ONE     = EW'(1 << FRAC_BITS);
  localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         in_cnt_q, in_cnt_d;
  logic [1:0]            sel_q, sel_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_last_q, s1_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  adv, in_hs, out_hs, in_is_last;
  logic signed [EW-1:0]  x_e, y_e, y_sat;
  logic [DATA_WIDTH-1:0] act_y;

  always_comb begin
    adv        = !out_valid_q || out_ready;
    in_ready   = !reset && enable && adv && (state_q == IDLE || state_q == RUN);
    in_hs      = in_valid && in_ready;
    out_hs     = out_valid_q && out_ready;
    in_is_last = (in_cnt_q == LAST_IDX);
  end

  // Activation uses the frame-latched select, so act_sel changes mid-frame have no effect.
  always_comb begin
    x_e = {{2{s1_data_q[DATA_WIDTH-1]}}, s1_data_q};
    y_e = x_e;
    case (sel_q)
      2'b01: y_e = x_e[EW-1] ? '0 : x_e;
      2'b10: y_e = x_e[EW-1] ? (x_e >>> 3) : x_e;
      2'b11: begin
        y_e = (x_e >>> 2) + HALF;
        if (y_e[EW-1]) y_e = '0;
        else if (y_e > ONE) y_e = ONE;
      end
      default: y_e = x_e;
    endcase
    if (y_e > SAT_MAX) y_sat = SAT_MAX;
    else if (y_e < SAT_MIN) y_sat = SAT_MIN;
    else y_sat = y_e;
    act_y = y_sat[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    sel_d       = sel_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (adv) begin
      s1_valid_d  = in_hs;
      s1_data_d   = in_data;
      s1_last_d   = in_is_last;
      out_valid_d = s1_valid_q;
      out_data_d  = s1_valid_q ? act_y : out_data_q;
      out_last_d  = s1_valid_q && s1_last_q;
    end

    if (in_hs && !in_is_last) in_cnt_d = in_cnt_q + 1'b1;

    case (state_q)
      IDLE: if (in_hs) begin
        sel_d   = act_sel;
        state_d = in_is_last ? DRAIN : RUN;
      end
      RUN:   if (in_hs && in_is_last) state_d = DRAIN;
      DRAIN: if (out_hs && out_last_q) begin
        state_d  = DONE;
        in_cnt_d = '0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      sel_q       <= 2'b00;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      sel_q       <= sel_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule
